// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: immediate generation, MEM/WB forwarding,
// load-use bubble insertion and branch/jump target computation feeding the ALU.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [31:0]       id_inst,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              id_hold,
    output logic              ex_valid,
    output logic [4:0]        ex_opcode,
    output logic [2:0]        ex_func3,
    output logic              ex_func7,
    output logic [XLEN-1:0]   ex_operand1,
    output logic [XLEN-1:0]   ex_operand2,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_target,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [4:0]        opcode;
        logic [2:0]        func3;
        logic              func7;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_state_t;

    // Bubble and reset state: addi x0,x0,0 marked invalid
    localparam ex_state_t EX_NOP = '{opcode: OPC_OPIMM, default: '0};

    ex_state_t         ex_q;
    ex_state_t         ex_next;
    logic [4:0]        id_opcode;
    logic [2:0]        id_func3;
    logic [REG_AW-1:0] id_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [XLEN-1:0]   id_imm;
    logic [XLEN-1:0]   id_rs1_byp;
    logic [XLEN-1:0]   id_rs2_byp;
    logic              id_writes;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              load_use;
    logic [XLEN-1:0]   rs1f;
    logic [XLEN-1:0]   rs2f;
    logic [XLEN-1:0]   jalr_sum;
    logic              unused_inst_bits;

    assign id_opcode        = id_inst[6:2];
    assign id_func3         = id_inst[14:12];
    assign id_rd            = id_inst[11:7];
    assign id_rs1           = id_inst[19:15];
    assign id_rs2           = id_inst[24:20];
    assign unused_inst_bits = &{1'b0, id_inst[1:0]};

    always_comb begin
        id_imm = '0;
        case (id_opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                id_imm = {{20{id_inst[31]}}, id_inst[31:20]};
            OPC_STORE:
                id_imm = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
            OPC_BRANCH:
                id_imm = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25],
                          id_inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                id_imm = {id_inst[31:12], 12'b0};
            OPC_JAL:
                id_imm = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20],
                          id_inst[30:21], 1'b0};
            default:
                id_imm = '0;
        endcase
    end

    always_comb begin
        id_writes = 1'b0;
        case (id_opcode)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_JAL, OPC_JALR: id_writes = 1'b1;
            default: id_writes = 1'b0;
        endcase
    end

    assign uses_rs1 = !(id_opcode == OPC_LUI || id_opcode == OPC_AUIPC || id_opcode == OPC_JAL);
    assign uses_rs2 = (id_opcode == OPC_OP) || (id_opcode == OPC_STORE) || (id_opcode == OPC_BRANCH);

    // A load in EX cannot forward in time, so a dependent ID instruction waits one cycle
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                      ((uses_rs1 && (id_rs1 == ex_q.rd)) || (uses_rs2 && (id_rs2 == ex_q.rd)));
    assign id_hold  = load_use && !stall && !flush;

    assign id_rs1_byp = (wb_reg_write && (id_rs1 != '0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
    assign id_rs2_byp = (wb_reg_write && (id_rs2 != '0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;

    always_comb begin
        ex_next           = EX_NOP;
        ex_next.valid     = id_valid;
        ex_next.pc        = id_pc;
        ex_next.opcode    = id_opcode;
        ex_next.func3     = id_func3;
        ex_next.func7     = id_inst[30] && ((id_opcode == OPC_OP) ||
                            ((id_opcode == OPC_OPIMM) && (id_func3 == 3'b101)));
        ex_next.rd        = id_rd;
        ex_next.rs1       = id_rs1;
        ex_next.rs2       = id_rs2;
        ex_next.imm       = id_imm;
        ex_next.rs1_data  = id_rs1_byp;
        ex_next.rs2_data  = id_rs2_byp;
        ex_next.reg_write = id_valid && id_writes && (id_rd != '0);
        ex_next.mem_read  = id_valid && (id_opcode == OPC_LOAD);
        ex_next.mem_write = id_valid && (id_opcode == OPC_STORE);
    end

    // During a stall the operand registers keep absorbing forwarded results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= EX_NOP;
        end else if (flush || (load_use && !stall)) begin
            ex_q <= EX_NOP;
        end else if (stall) begin
            ex_q.rs1_data <= rs1f;
            ex_q.rs2_data <= rs2f;
        end else begin
            ex_q <= ex_next;
        end
    end

    function automatic logic [XLEN-1:0] forward(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   reg_val,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_dst,
        input logic [XLEN-1:0]   mem_val,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_dst,
        input logic [XLEN-1:0]   wb_val
    );
        if (rs == '0)
            return '0;
        else if (mem_we && (mem_dst == rs))
            return mem_val;
        else if (wb_we && (wb_dst == rs))
            return wb_val;
        else
            return reg_val;
    endfunction

    assign rs1f = forward(ex_q.rs1, ex_q.rs1_data, mem_reg_write, mem_rd, mem_fwd_data,
                          wb_reg_write, wb_rd, wb_data);
    assign rs2f = forward(ex_q.rs2, ex_q.rs2_data, mem_reg_write, mem_rd, mem_fwd_data,
                          wb_reg_write, wb_rd, wb_data);

    always_comb begin
        ex_operand1 = '0;
        ex_operand2 = '0;
        case (ex_q.opcode)
            OPC_OP, OPC_BRANCH: begin
                ex_operand1 = rs1f;
                ex_operand2 = rs2f;
            end
            OPC_OPIMM, OPC_LOAD, OPC_STORE: begin
                ex_operand1 = rs1f;
                ex_operand2 = ex_q.imm;
            end
            OPC_LUI: begin
                ex_operand2 = ex_q.imm;
            end
            OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                ex_operand1 = ex_q.pc;
                ex_operand2 = ex_q.imm;
            end
            default: begin
                ex_operand1 = '0;
                ex_operand2 = '0;
            end
        endcase
    end

    assign jalr_sum      = rs1f + ex_q.imm;
    assign ex_target     = (ex_q.opcode == OPC_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : ex_q.pc + ex_q.imm;
    assign ex_store_data = rs2f;
    assign ex_valid      = ex_q.valid;
    assign ex_opcode     = ex_q.opcode;
    assign ex_func3      = ex_q.func3;
    assign ex_func7      = ex_q.func7;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule
